mii_tx_frame_scheduler: RTL and testbench

- Shares one MII 100Base-T transmit port between p_NUM_SOURCES byte-stream frame sources.
- Arbitrates round-robin per frame, prepends preamble/SFD, serialises bytes to nibbles (low nibble first), enforces the inter-frame gap, and aborts cleanly on source underrun.
- Sits in the i_phy_port0_tx_clk domain, between protocol engines (ARP responder, UDP TX) and the PHY's o_phy_port0_tx_d/o_phy_port0_tx_en pins.
- Sources supply complete frames including FCS; no CRC generation or padding here.

---
 rtl/mii_tx_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mii_tx_frame_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// mii_tx_frame_scheduler
//
// Shares one 100Base-T MII transmit port between several byte-stream frame
// sources. Whole frames are granted round-robin; each granted frame goes out
// as preamble, SFD, then its bytes split into nibbles (low nibble first).
// The minimum inter-frame gap is held between frames. If a source runs dry
// mid-frame, the frame is aborted and the rest of that frame is discarded.
// Sources deliver complete frames including FCS; nothing is added here
// except preamble and SFD.
//
// Ports
//   i_clock      MII TX clock (25 MHz); everything lives in this domain
//   i_reset_n    synchronous reset, active low
//   i_s_tdata    one byte per source, source k on [8k+7:8k]
//   i_s_tvalid   byte valid, one bit per source
//   i_s_tlast    last byte of frame, one bit per source
//   o_s_tready   byte accept, one bit per source (only the granted source)
//   o_tx_d       MII TXD nibble, registered
//   o_tx_en      MII TX_EN, registered
//   o_grant      one-hot owner of the frame in flight, registered
//   o_busy       high whenever the scheduler is not idle
//   o_underrun   one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
module mii_tx_frame_scheduler #(
    parameter int p_NUM_SOURCES      = 2,
    parameter int p_PREAMBLE_NIBBLES = 15,
    parameter int p_IFG_NIBBLES      = 24
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic [8*p_NUM_SOURCES-1:0]   i_s_tdata,
    input  logic [p_NUM_SOURCES-1:0]     i_s_tvalid,
    input  logic [p_NUM_SOURCES-1:0]     i_s_tlast,
    output logic [p_NUM_SOURCES-1:0]     o_s_tready,
    output logic [3:0]                   o_tx_d,
    output logic                         o_tx_en,
    output logic [p_NUM_SOURCES-1:0]     o_grant,
    output logic                         o_busy,
    output logic                         o_underrun
);

    localparam int PTR_W = (p_NUM_SOURCES > 1) ? $clog2(p_NUM_SOURCES) : 1;
    localparam int PRE_W = $clog2(p_PREAMBLE_NIBBLES + 1);
    localparam int IFG_W = $clog2(p_IFG_NIBBLES + 1);

    // The IDLE arbitration cycle is itself one of the low TX_EN cycles, so
    // the IFG state only has to cover the remaining p_IFG_NIBBLES-1 cycles.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(p_PREAMBLE_NIBBLES - 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(p_IFG_NIBBLES - 2);

    localparam logic [3:0] NIB_PREAMBLE = 4'h5;
    localparam logic [3:0] NIB_SFD      = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_DRAIN,
        ST_IFG
    } state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [p_NUM_SOURCES-1:0]   grant_q, grant_d;
    logic [PRE_W-1:0]           preCnt_q, preCnt_d;
    logic [IFG_W-1:0]           ifgCnt_q, ifgCnt_d;
    logic [7:0]                 hold_q, hold_d;
    logic                       holdLast_q, holdLast_d;
    logic [3:0]                 txD_q, txD_d;
    logic                       txEn_q, txEn_d;
    logic                       underrun_q, underrun_d;

    logic [p_NUM_SOURCES-1:0]   arbGrant;
    logic [PTR_W-1:0]           arbNextPtr;
    logic [7:0]                 selData;
    logic                       selValid;
    logic                       selLast;

    // Round-robin arbiter: walk the sources starting at the pointer and
    // wrapping, and take the first one with tvalid high. The pointer for the
    // next frame is the source after the winner, again wrapping.
    always_comb begin
        logic found;
        found      = 1'b0;
        arbGrant   = '0;
        arbNextPtr = '0;
        for (int i = 0; i < p_NUM_SOURCES; i++) begin
            for (int j = 0; j < p_NUM_SOURCES; j++) begin
                if (((int'(ptr_q) + i) % p_NUM_SOURCES) == j) begin
                    if (!found && i_s_tvalid[j]) begin
                        found       = 1'b1;
                        arbGrant[j] = 1'b1;
                        arbNextPtr  = (j == p_NUM_SOURCES - 1) ? '0 : PTR_W'(j + 1);
                    end
                end
            end
        end
    end

    // Mux the granted source's stream onto a single byte/valid/last view.
    // The grant register is one-hot, so an AND-OR select is enough.
    always_comb begin
        selData = '0;
        for (int k = 0; k < p_NUM_SOURCES; k++) begin
            if (grant_q[k]) begin
                selData = i_s_tdata[8*k +: 8];
            end
        end
    end

    assign selValid = |(i_s_tvalid & grant_q);
    assign selLast  = |(i_s_tlast & grant_q);

    // Ready is offered only in the cycles where a byte is due (SFD and the
    // high-nibble cycle of a non-final byte) or while draining an aborted
    // frame, and only to the granted source.
    always_comb begin
        case (state_q)
            ST_SFD:     o_s_tready = grant_q;
            ST_DATA_HI: o_s_tready = holdLast_q ? '0 : grant_q;
            ST_DRAIN:   o_s_tready = grant_q;
            default:    o_s_tready = '0;
        endcase
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_tx_d     = txD_q;
    assign o_tx_en    = txEn_q;
    assign o_grant    = grant_q;
    assign o_underrun = underrun_q;

    // Next-state logic. The MII pins are registered from the current state,
    // so the nibble a state produces appears on the pins one cycle after the
    // state is entered. Any cycle that does not explicitly drive TX_EN
    // leaves it low with TXD at zero.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        preCnt_d   = preCnt_q;
        ifgCnt_d   = ifgCnt_q;
        hold_d     = hold_q;
        holdLast_d = holdLast_q;
        txD_d      = 4'h0;
        txEn_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|i_s_tvalid) begin
                    grant_d  = arbGrant;
                    ptr_d    = arbNextPtr;
                    preCnt_d = '0;
                    state_d  = ST_PREAMBLE;
                end else begin
                    grant_d = '0;
                end
            end

            ST_PREAMBLE: begin
                txD_d  = NIB_PREAMBLE;
                txEn_d = 1'b1;
                if (preCnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                end else begin
                    preCnt_d = preCnt_q + PRE_W'(1);
                end
            end

            ST_SFD: begin
                if (selValid) begin
                    txD_d      = NIB_SFD;
                    txEn_d     = 1'b1;
                    hold_d     = selData;
                    holdLast_d = selLast;
                    state_d    = ST_DATA_LO;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end

            ST_DATA_LO: begin
                txD_d   = hold_q[3:0];
                txEn_d  = 1'b1;
                state_d = ST_DATA_HI;
            end

            ST_DATA_HI: begin
                if (holdLast_q) begin
                    txD_d    = hold_q[7:4];
                    txEn_d   = 1'b1;
                    grant_d  = '0;
                    ifgCnt_d = '0;
                    state_d  = ST_IFG;
                end else if (selValid) begin
                    txD_d      = hold_q[7:4];
                    txEn_d     = 1'b1;
                    hold_d     = selData;
                    holdLast_d = selLast;
                    state_d    = ST_DATA_LO;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (selValid && selLast) begin
                    grant_d  = '0;
                    ifgCnt_d = '0;
                    state_d  = ST_IFG;
                end
            end

            ST_IFG: begin
                if (ifgCnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ifgCnt_d = ifgCnt_q + IFG_W'(1);
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and output registers. Reset drops everything to idle on the
    // sampling edge, which truncates any frame in flight immediately.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            preCnt_q   <= '0;
            ifgCnt_q   <= '0;
            hold_q     <= '0;
            holdLast_q <= 1'b0;
            txD_q      <= 4'h0;
            txEn_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            preCnt_q   <= preCnt_d;
            ifgCnt_q   <= ifgCnt_d;
            hold_q     <= hold_d;
            holdLast_q <= holdLast_d;
            txD_q      <= txD_d;
            txEn_q     <= txEn_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_mii_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mii_tx_frame_scheduler
//
// Directed bench for mii_tx_frame_scheduler with two frame sources. Each
// source is a small behavioural AXI-stream model that replays a byte ramp,
// optionally stalling once; a monitor logs the MII nibbles, TX_EN run and
// gap lengths, and grants so scenarios can be compared with hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_mii_tx_frame_scheduler;

    logic        clock;
    logic        resetN;
    logic [15:0] sTdata;
    logic [1:0]  sTvalid;
    logic [1:0]  sTlast;
    logic [1:0]  sTready;
    logic [3:0]  txD;
    logic        txEn;
    logic [1:0]  grant;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] frameMem [2][64];
    int         frameLen   [2];
    int         srcPos     [2];
    int         framesLeft [2];
    int         stallAt    [2];
    int         stallLeft  [2];
    int         hsCount    [2];
    bit         srcActive  [2];
    logic [1:0] hsPending;

    int         enCycles;
    int         enRun;
    int         lowRun;
    int         urCycles;
    int         illegalReady;
    logic [3:0] urTxD;
    logic       urTxEn;
    logic       prevEn;
    logic [1:0] prevGrant;
    logic [3:0] nibLog[$];
    int         gapLog[$];
    int         enRunLog[$];
    logic [1:0] grantLog[$];

    mii_tx_frame_scheduler #(
        .p_NUM_SOURCES      (2),
        .p_PREAMBLE_NIBBLES (15),
        .p_IFG_NIBBLES      (24)
    ) dut (
        .i_clock    (clock),
        .i_reset_n  (resetN),
        .i_s_tdata  (sTdata),
        .i_s_tvalid (sTvalid),
        .i_s_tlast  (sTlast),
        .o_s_tready (sTready),
        .o_tx_d     (txD),
        .o_tx_en    (txEn),
        .o_grant    (grant),
        .o_busy     (busy),
        .o_underrun (underrun)
    );

    // 25 MHz MII transmit clock.
    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Hard stop in case some scenario never lets the design go idle.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        enCycles     = 0;
        enRun        = 0;
        lowRun       = 0;
        urCycles     = 0;
        urTxD        = 4'h0;
        urTxEn       = 1'b0;
        prevEn       = 1'b0;
        prevGrant    = 2'b00;
        nibLog.delete();
        gapLog.delete();
        enRunLog.delete();
        grantLog.delete();
    endtask

    // Present each active source's current byte; the recorded handshake is
    // the one that will happen on the coming rising edge.
    task automatic driveSources();
        for (int k = 0; k < 2; k++) begin
            if (srcActive[k] && srcPos[k] == stallAt[k] && stallLeft[k] > 0) begin
                sTvalid[k]       = 1'b0;
                sTdata[8*k +: 8] = 8'h00;
                sTlast[k]        = 1'b0;
                stallLeft[k]--;
            end else if (srcActive[k]) begin
                sTvalid[k]       = 1'b1;
                sTdata[8*k +: 8] = frameMem[k][srcPos[k]];
                sTlast[k]        = (srcPos[k] == frameLen[k] - 1);
            end else begin
                sTvalid[k]       = 1'b0;
                sTdata[8*k +: 8] = 8'h00;
                sTlast[k]        = 1'b0;
            end
        end
        hsPending = sTready & sTvalid;
    endtask

    // One clock cycle: sample outputs on the falling edge, retire the
    // handshake from the previous rising edge, then drive new inputs.
    task automatic applyStimulus();
        @(negedge clock);
        if (txEn) begin
            if (!prevEn) begin
                gapLog.push_back(lowRun);
                lowRun = 0;
            end
            enCycles++;
            enRun++;
            nibLog.push_back(txD);
        end else begin
            if (prevEn) begin
                enRunLog.push_back(enRun);
                enRun = 0;
            end
            lowRun++;
        end
        if (grant != 2'b00 && prevGrant == 2'b00) grantLog.push_back(grant);
        if (underrun) begin
            urCycles++;
            urTxD  = txD;
            urTxEn = txEn;
        end
        if ((sTready & ~grant) != 2'b00) illegalReady++;
        prevEn    = txEn;
        prevGrant = grant;

        for (int k = 0; k < 2; k++) begin
            if (hsPending[k]) begin
                hsCount[k]++;
                srcPos[k]++;
                if (srcPos[k] == frameLen[k]) begin
                    srcPos[k] = 0;
                    framesLeft[k]--;
                    if (framesLeft[k] == 0) srcActive[k] = 1'b0;
                end
            end
        end
        driveSources();
    endtask

    task automatic loadFrame(input int k, input int len, input int base, input int frames, input int stallPos, input int stallCycles);
        for (int i = 0; i < len; i++) frameMem[k][i] = 8'(base + i);
        frameLen[k]   = len;
        srcPos[k]     = 0;
        framesLeft[k] = frames;
        stallAt[k]    = stallPos;
        stallLeft[k]  = stallCycles;
        hsCount[k]    = 0;
        srcActive[k]  = 1'b1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " tx_en"},    32'(txEn),     32'd0);
        checkOutput({tag, " tx_d"},     32'(txD),      32'd0);
        checkOutput({tag, " grant"},    32'(grant),    32'd0);
        checkOutput({tag, " busy"},     32'(busy),     32'd0);
        checkOutput({tag, " underrun"}, 32'(underrun), 32'd0);
        checkOutput({tag, " tready"},   32'(sTready),  32'd0);
    endtask

    // Holds reset for three cycles with all sources quiet, checks the
    // reset-state outputs, then releases reset with a fresh monitor.
    task automatic resetDut(input string tag);
        resetN       = 1'b0;
        srcActive[0] = 1'b0;
        srcActive[1] = 1'b0;
        driveSources();
        repeat (3) applyStimulus();
        checkIdleOutputs(tag);
        resetN = 1'b1;
        clearMonitor();
    endtask

    task automatic runUntilIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while ((srcActive[0] || srcActive[1] || busy) && n < maxCycles);
        checkOutput({tag, " finished in budget"}, 32'(n < maxCycles), 32'd1);
    endtask

    // Expected single-frame nibble stream: 15 preamble, SFD, then each byte
    // of the ramp low nibble first.
    task automatic checkNibbles(input string tag, input int base, input int nBytes);
        logic [3:0] expNib[$];
        logic [7:0] b;
        int         bad;
        bad = 0;
        for (int i = 0; i < 15; i++) expNib.push_back(4'h5);
        expNib.push_back(4'hD);
        for (int i = 0; i < nBytes; i++) begin
            b = 8'(base + i);
            expNib.push_back(b[3:0]);
            expNib.push_back(b[7:4]);
        end
        checkOutput({tag, " nibble count"}, 32'(nibLog.size()), 32'(expNib.size()));
        for (int i = 0; i < expNib.size(); i++) begin
            if (i >= nibLog.size() || nibLog[i] !== expNib[i]) bad++;
        end
        checkOutput({tag, " nibble errors"}, 32'(bad), 32'd0);
    endtask

    function automatic logic [31:0] grantAt(input int i);
        return (i < grantLog.size()) ? 32'(grantLog[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gapAt(input int i);
        return (i < gapLog.size()) ? 32'(gapLog[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] enRunAt(input int i);
        return (i < enRunLog.size()) ? 32'(enRunLog[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n;
        resetN       = 1'b0;
        sTvalid      = 2'b00;
        sTlast       = 2'b00;
        sTdata       = 16'h0000;
        hsPending    = 2'b00;
        illegalReady = 0;
        for (int k = 0; k < 2; k++) begin
            srcActive[k] = 1'b0;
            stallAt[k]   = -1;
            stallLeft[k] = 0;
            hsCount[k]   = 0;
        end
        clearMonitor();

        // Reset state, then a single 64-byte ramp from source 0.
        resetDut("reset");
        loadFrame(0, 64, 8'h00, 1, -1, 0);
        runUntilIdle("t1", 400);
        checkOutput("t1 tx_en high cycles", 32'(enCycles), 32'd144);
        checkOutput("t1 tx_en single run", enRunAt(0), 32'd144);
        checkNibbles("t1", 8'h00, 64);
        checkOutput("t1 handshakes", 32'(hsCount[0]), 32'd64);
        checkOutput("t1 grant", grantAt(0), 32'h1);
        checkOutput("t1 no underrun", 32'(urCycles), 32'd0);

        // Both sources continuously valid, two 4-byte frames each.
        resetDut("t2 reset");
        loadFrame(0, 4, 8'h10, 2, -1, 0);
        loadFrame(1, 4, 8'h20, 2, -1, 0);
        runUntilIdle("t2", 600);
        checkOutput("t2 grant count", 32'(grantLog.size()), 32'd4);
        checkOutput("t2 grant 0", grantAt(0), 32'h1);
        checkOutput("t2 grant 1", grantAt(1), 32'h2);
        checkOutput("t2 grant 2", grantAt(2), 32'h1);
        checkOutput("t2 grant 3", grantAt(3), 32'h2);
        checkOutput("t2 gap 1", gapAt(1), 32'd24);
        checkOutput("t2 gap 2", gapAt(2), 32'd24);
        checkOutput("t2 gap 3", gapAt(3), 32'd24);
        checkOutput("t2 tx_en high cycles", 32'(enCycles), 32'd96);

        // Source 1 alone first, then a simultaneous request goes to 0.
        resetDut("t3 reset");
        loadFrame(1, 2, 8'h60, 1, -1, 0);
        runUntilIdle("t3a", 200);
        checkOutput("t3 first grant", grantAt(0), 32'h2);
        loadFrame(0, 2, 8'h70, 1, -1, 0);
        loadFrame(1, 2, 8'h80, 1, -1, 0);
        runUntilIdle("t3b", 300);
        checkOutput("t3 simultaneous grant", grantAt(1), 32'h1);
        checkOutput("t3 following grant", grantAt(2), 32'h2);

        // Underrun: source 0 stalls 3 cycles after 10 of 20 bytes while
        // source 1 waits with a 4-byte frame.
        resetDut("t4 reset");
        loadFrame(0, 20, 8'h00, 1, 10, 3);
        loadFrame(1, 4, 8'h90, 1, -1, 0);
        runUntilIdle("t4", 600);
        checkOutput("t4 aborted run length", enRunAt(0), 32'd35);
        checkOutput("t4 underrun cycles", 32'(urCycles), 32'd1);
        checkOutput("t4 tx_en at underrun", 32'(urTxEn), 32'd0);
        checkOutput("t4 tx_d at underrun", 32'(urTxD), 32'd0);
        checkOutput("t4 src0 drained bytes", 32'(hsCount[0]), 32'd20);
        checkOutput("t4 src1 bytes", 32'(hsCount[1]), 32'd4);
        checkOutput("t4 grant 0", grantAt(0), 32'h1);
        checkOutput("t4 grant 1", grantAt(1), 32'h2);
        checkOutput("t4 gap after abort", gapAt(1), 32'd36);

        // One-byte frame.
        resetDut("t5 reset");
        loadFrame(0, 1, 8'hA5, 1, -1, 0);
        runUntilIdle("t5", 200);
        checkNibbles("t5", 8'hA5, 1);
        checkOutput("t5 run length", enRunAt(0), 32'd18);
        checkOutput("t5 handshakes", 32'(hsCount[0]), 32'd1);

        // Reset pulse in the middle of a frame, then a clean frame from 1.
        resetDut("t6 reset");
        loadFrame(0, 20, 8'h40, 1, -1, 0);
        n = 0;
        while (nibLog.size() < 20 && n < 100) begin
            applyStimulus();
            n++;
        end
        checkOutput("t6 reached data", 32'(nibLog.size() >= 20), 32'd1);
        checkOutput("t6 tx_en before reset", 32'(txEn), 32'd1);
        resetN       = 1'b0;
        srcActive[0] = 1'b0;
        driveSources();
        applyStimulus();
        checkIdleOutputs("t6 after reset edge");
        resetN = 1'b1;
        clearMonitor();
        loadFrame(1, 3, 8'h30, 1, -1, 0);
        runUntilIdle("t6", 200);
        checkOutput("t6 grant", grantAt(0), 32'h2);
        checkNibbles("t6", 8'h30, 3);
        checkOutput("t6 run length", enRunAt(0), 32'd22);

        checkOutput("tready only to granted source", 32'(illegalReady), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
